// File: rtl/tt_sel_pkg.sv
// Shared types and helpers for the tiny-tapeout selection controller:
// FSM encoding, spine address field widths and the address packing function.
package tt_sel_pkg;

    localparam int ROW_W  = 4;
    localparam int UM_W   = 5;
    localparam int ADDR_W = ROW_W + UM_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GATE   = 2'd3
    } sel_state_e;

    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [ROW_W-1:0] row,
        input logic [UM_W-1:0]  um
    );
        return {row, um};
    endfunction

endpackage

// File: rtl/tt_pad_sync.sv
// Two-flop synchronizer for an asynchronous pad, with an optional debounce
// filter and a one-cycle rising-edge pulse on the filtered level.
module tt_pad_sync #(
    parameter int DEB_CYCLES = 4,
    parameter bit BYPASS     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The filter only follows the synchronized level after it has differed
    // for DEB_CYCLES cycles in a row; any return to the old level restarts.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (BYPASS) begin
            filt_d = sync2_q;
        end else if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = filt_d & ~filt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = BYPASS ? sync2_q : filt_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/tt_sel_ctrl.sv
// User-module selection controller: walks the spine address on debounced
// sel_inc pulses and sequences spine_ena so the address never moves while enabled.
module tt_sel_ctrl
    import tt_sel_pkg::*;
#(
    parameter int G_X           = 16,
    parameter int G_Y           = 24,
    parameter int DEB_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    output logic [ADDR_W-1:0] spine_addr,
    output logic              spine_ena,
    output logic              sel_busy
);

    localparam int UM_MAX  = 2 * G_X - 1;
    localparam int ROW_MAX = G_Y / 2 - 1;
    localparam int SCNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PAD_INC = 0;

    logic [2:0] pad_vec;
    logic [2:0] pad_level;
    logic [2:0] pad_rise;
    logic       unused_pad;

    assign pad_vec = {ctrl_ena, ctrl_sel_rst_n, ctrl_sel_inc};

    for (genvar gi = 0; gi < 3; gi++) begin : g_pad
        tt_pad_sync #(
            .DEB_CYCLES (DEB_CYCLES),
            .BYPASS     (gi != PAD_INC)
        ) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad_i   (pad_vec[gi]),
            .level_o (pad_level[gi]),
            .rise_o  (pad_rise[gi])
        );
    end

    logic inc_pulse, sel_rst_lvl, ena_lvl;
    assign inc_pulse   = pad_rise[PAD_INC];
    assign sel_rst_lvl = pad_level[1];
    assign ena_lvl     = pad_level[2];
    assign unused_pad  = ^{pad_rise[2:1], pad_level[PAD_INC]};

    sel_state_e        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d, row_inc;
    logic [UM_W-1:0]   um_q, um_d, um_inc;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              ena_q, ena_d;
    logic              busy_q, busy_d;
    logic              advance;

    // Address successor: um wraps into the next row, the last row wraps to 0.
    always_comb begin
        um_inc  = um_q + 1'b1;
        row_inc = row_q;
        if (um_q == UM_W'(UM_MAX)) begin
            um_inc  = '0;
            row_inc = (row_q == ROW_W'(ROW_MAX)) ? '0 : row_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        um_d    = um_q;
        scnt_d  = scnt_q;
        ena_d   = ena_q;
        advance = 1'b0;
        if (!sel_rst_lvl) begin
            state_d = ST_IDLE;
            row_d   = '0;
            um_d    = '0;
            scnt_d  = '0;
            ena_d   = 1'b0;
        end else if (!ena_lvl) begin
            state_d = ST_IDLE;
            scnt_d  = '0;
            ena_d   = 1'b0;
            advance = inc_pulse && (state_q == ST_IDLE || state_q == ST_SETTLE);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    scnt_d  = '0;
                    advance = inc_pulse;
                end
                ST_SETTLE: begin
                    if (inc_pulse) begin
                        advance = 1'b1;
                        scnt_d  = '0;
                    end else if (scnt_q == SCNT_W'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_ACTIVE;
                        scnt_d  = '0;
                        ena_d   = 1'b1;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (inc_pulse) begin
                        state_d = ST_GATE;
                        ena_d   = 1'b0;
                    end
                end
                // Enable already dropped last edge, so moving the address is safe.
                ST_GATE: begin
                    advance = 1'b1;
                    state_d = ST_SETTLE;
                    scnt_d  = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (advance) begin
            row_d = row_inc;
            um_d  = um_inc;
        end
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_GATE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            um_q    <= '0;
            scnt_q  <= '0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            um_q    <= um_d;
            scnt_q  <= scnt_d;
            ena_q   <= ena_d;
            busy_q  <= busy_d;
        end
    end

    assign spine_addr = pack_addr(row_q, um_q);
    assign spine_ena  = ena_q;
    assign sel_busy   = busy_q;

endmodule
